// File: rtl/alu_sequencer.sv
// alu_sequencer -- multi-cycle sequencer for Hack-format instructions driving an
// external combinational ALU.
//
// A-instructions retire in one cycle: A is loaded and pc is advanced.
// C-instructions go through IDLE -> EXEC -> WB.
//   - EXEC presents the operands and control bits to the external ALU and
//     captures its result.
//   - WB commits that result to the A, D and memory destinations and resolves
//     the jump.
//
// Ports:
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   instr[15:0], instr_valid     offered instruction word
//   instr_ready                  high in IDLE (and not in reset): offer is taken
//   zx, nx, zy, ny, f, no        ALU control bits, valid only in EXEC
//   alu_x, alu_y                 ALU operands (D and A/M), zero outside EXEC
//   alu_in                       ALU result
//   m_addr, m_in                 memory address (always A) and its async read data
//   m_wdata, m_we                memory write data and strobe (WB with d[0] only)
//   pc, res_valid                program counter, one-cycle retire pulse
//   a_reg, d_reg                 architectural A and D registers
//   retired                      retire counter (only with ALU_SEQ_RETIRE_CNT_EN)
//
// Build option:
//   ALU_SEQ_RETIRE_CNT_EN        when defined, adds the 16-bit `retired` output,
//                                which counts retire pulses.

module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_in,
    output logic [15:0] m_addr,
    input  logic [15:0] m_in,
    output logic [15:0] m_wdata,
    output logic        m_we,
    output logic [15:0] pc,
    output logic        res_valid,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   a_q, d_q, pc_q;
    logic [DATA_W-1:0]   ir_p0;     // C-instr captured at accept
    logic [DATA_W-1:0]   res_p1;    // ALU result captured in EXEC
    logic                vld_p2;    // retire pulse
    logic                in_exec, in_wb;

    // Hack jump condition on the captured result.
    function automatic logic jump_taken(input logic [DATA_W-1:0] res, input logic [2:0] j);
        logic zr, ng;
        zr = (res == '0);
        ng = res[DATA_W-1];
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

    // Reset gates the datapath strobes even while the state register still
    // holds EXEC/WB, so an aborted instruction has no visible effect.
    assign in_exec = (state == EXEC) && !reset;
    assign in_wb   = (state == WB) && !reset;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (instr_valid && instr[15]) state_n = EXEC;
            EXEC:    state_n = WB;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        {zx, nx, zy, ny, f, no} = 6'b0;
        alu_x = '0;
        alu_y = '0;
        m_we  = 1'b0;
        if (state == IDLE && !reset) instr_ready = 1'b1;
        if (in_exec) begin
            {zx, nx, zy, ny, f, no} = ir_p0[11:6];
            alu_x = d_q;
            alu_y = ir_p0[12] ? m_in : a_q;
        end
        if (in_wb) m_we = ir_p0[3];
    end

    // m_addr stays on the pre-update A through WB, so a memory write lands at
    // the old A even when A is also a destination of the same instruction.
    assign m_addr    = a_q;
    assign m_wdata   = res_p1;
    assign pc        = pc_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;
    assign res_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_q    <= '0;
            d_q    <= '0;
            pc_q   <= '0;
            ir_p0  <= '0;
            res_p1 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            state  <= state_n;
            vld_p2 <= 1'b0;
            case (state)
                // stage: accept
                IDLE: begin
                    if (instr_valid) begin
                        if (!instr[15]) begin
                            a_q    <= {1'b0, instr[14:0]};
                            pc_q   <= pc_q + 16'd1;
                            vld_p2 <= 1'b1;
                        end else begin
                            ir_p0 <= instr;
                        end
                    end
                end
                // stage: execute
                EXEC: res_p1 <= alu_in;
                // stage: write-back; jump target is the A value before this update
                WB: begin
                    if (ir_p0[5]) a_q <= res_p1;
                    if (ir_p0[4]) d_q <= res_p1;
                    pc_q   <= jump_taken(res_p1, ir_p0[2:0]) ? a_q : pc_q + 16'd1;
                    vld_p2 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)       retired <= '0;
        else if (vld_p2) retired <= retired + 16'd1;
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        zx, nx, zy, ny, f, no;
    logic [15:0] alu_x, alu_y, alu_in;
    logic [15:0] m_addr, m_in, m_wdata;
    logic        m_we;
    logic [15:0] pc;
    logic        res_valid;
    logic [15:0] a_reg, d_reg;
`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] ma, md, mpc;
    logic [15:0] mem [0:255];
    logic [15:0] model_mem [0:255];

    alu_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .alu_x(alu_x), .alu_y(alu_y), .alu_in(alu_in), .m_addr(m_addr), .m_in(m_in),
        .m_wdata(m_wdata), .m_we(m_we), .pc(pc), .res_valid(res_valid),
        .a_reg(a_reg), .d_reg(d_reg)
`ifdef ALU_SEQ_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // Reference Hack ALU, used both as the external ALU and by the model.
    function automatic logic [15:0] hack_alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                             input logic [5:0] c);
        logic [15:0] x, y, o;
        x = x_in;
        y = y_in;
        if (c[5]) x = '0;
        if (c[4]) x = ~x;
        if (c[3]) y = '0;
        if (c[2]) y = ~y;
        o = c[1] ? x + y : x & y;
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_in = hack_alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
    assign m_in   = mem[m_addr[7:0]];

    always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;

    // Architectural model: computes the post-retire state and queues it.
    function automatic void model_step(input logic [15:0] ins);
        logic [15:0] y, res, pre_a;
        logic zr, ng, jmp;
        exp_t e;
        if (!ins[15]) begin
            ma  = {1'b0, ins[14:0]};
            mpc = mpc + 16'd1;
        end else begin
            pre_a = ma;
            y   = ins[12] ? model_mem[ma[7:0]] : ma;
            res = hack_alu(md, y, ins[11:6]);
            zr  = (res == 16'd0);
            ng  = res[15];
            jmp = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
            mpc = jmp ? pre_a : mpc + 16'd1;
            if (ins[5]) ma = res;
            if (ins[4]) md = res;
            if (ins[3]) model_mem[pre_a[7:0]] = res;
        end
        e.pc = mpc;
        e.a  = ma;
        e.d  = md;
        expq.push_back(e);
    endfunction

    // Scoreboard: every retire pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (res_valid) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL retire_unexpected pc=%h a=%h d=%h required=no retire", pc, a_reg, d_reg);
            end else begin
                exp_t e;
                e = expq.pop_front();
                if ({pc, a_reg, d_reg} !== {e.pc, e.a, e.d}) begin
                    failures++;
                    $display("FAIL retire_state pc/a/d=%h/%h/%h required=%h/%h/%h",
                             pc, a_reg, d_reg, e.pc, e.a, e.d);
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins, input bit track);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout instr_ready=%b required=1", instr_ready);
        end
        instr = ins;
        instr_valid = 1'b1;
        if (track) model_step(ins);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // Returns on the first negedge with instr_ready high (the retire cycle).
    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_ready_timeout instr_ready=%b required=1", instr_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        expq.delete();
        ma = '0; md = '0; mpc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({instr_ready, m_we, res_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold ready/we/vld=%b required=000", {instr_ready, m_we, res_valid});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({pc, a_reg, d_reg} !== 48'd0) begin
            failures++;
            $display("FAIL reset_regs pc/a/d=%h/%h/%h required=0/0/0", pc, a_reg, d_reg);
        end
        checks++;
        if ({res_valid, m_we, zx, nx, zy, ny, f, no} !== 8'd0) begin
            failures++;
            $display("FAIL reset_after_outputs got=%b required=00000000",
                     {res_valid, m_we, zx, nx, zy, ny, f, no});
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b required=1", instr_ready);
        end
    endtask

    task automatic test_a_instr();
        send(16'h0005, 1);
        @(negedge clk);
        checks++;
        if ({res_valid, a_reg, pc} !== {1'b1, 16'h0005, 16'h0001}) begin
            failures++;
            $display("FAIL a_instr vld/a/pc=%b/%h/%h required=1/0005/0001", res_valid, a_reg, pc);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL a_instr_pulse res_valid=%b required=0", res_valid);
        end
    endtask

    task automatic test_c_dest_d();
        send(16'hEC10, 1);
        @(negedge clk);
        checks++;
        if ({zx, nx, zy, ny, f, no} !== 6'b110000 || alu_y !== 16'h0005 || alu_x !== 16'h0000) begin
            failures++;
            $display("FAIL c_exec ctrl/x/y=%b/%h/%h required=110000/0000/0005",
                     {zx, nx, zy, ny, f, no}, alu_x, alu_y);
        end
        checks++;
        if (instr_ready !== 1'b0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL c_exec_busy ready/vld=%b%b required=00", instr_ready, res_valid);
        end
        @(negedge clk);
        checks++;
        if (m_we !== 1'b0 || res_valid !== 1'b0 || {zx, nx, zy, ny, f, no} !== 6'b0) begin
            failures++;
            $display("FAIL c_wb we/vld/ctrl=%b/%b/%b required=0/0/000000",
                     m_we, res_valid, {zx, nx, zy, ny, f, no});
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || d_reg !== 16'h0005) begin
            failures++;
            $display("FAIL c_retire vld/d=%b/%h required=1/0005", res_valid, d_reg);
        end
    endtask

    task automatic test_mem_write();
        send(16'h0003, 1);
        send(16'hEC10, 1);
        send(16'h0010, 1);
        send(16'hE308, 1);
        @(negedge clk);
        checks++;
        if (m_we !== 1'b0) begin
            failures++;
            $display("FAIL mem_exec_we got=%b required=0", m_we);
        end
        @(negedge clk);
        checks++;
        if ({m_we, m_addr, m_wdata} !== {1'b1, 16'h0010, 16'h0003}) begin
            failures++;
            $display("FAIL mem_wb we/addr/wdata=%b/%h/%h required=1/0010/0003", m_we, m_addr, m_wdata);
        end
        @(negedge clk);
        checks++;
        if (m_we !== 1'b0) begin
            failures++;
            $display("FAIL mem_we_pulse got=%b required=0", m_we);
        end
        checks++;
        if (mem[8'h10] !== 16'h0003 || a_reg !== 16'h0010 || d_reg !== 16'h0003) begin
            failures++;
            $display("FAIL mem_state mem/a/d=%h/%h/%h required=0003/0010/0003", mem[8'h10], a_reg, d_reg);
        end
    endtask

    task automatic test_jump();
        logic [15:0] old_pc;
        send(16'h0000, 1);
        send(16'hEC10, 1);
        send(16'h0020, 1);
        send(16'hE302, 1);
        wait_ready();
        checks++;
        if (pc !== 16'h0020) begin
            failures++;
            $display("FAIL jeq_taken pc=%h required=0020", pc);
        end
        send(16'h0001, 1);
        send(16'hEC10, 1);
        send(16'h0020, 1);
        old_pc = mpc;
        send(16'hE302, 1);
        wait_ready();
        checks++;
        if (pc !== old_pc + 16'd1) begin
            failures++;
            $display("FAIL jeq_not_taken pc=%h required=%h", pc, old_pc + 16'd1);
        end
        send(16'h0030, 1);
        send(16'hE32F, 1);
        wait_ready();
        checks++;
        if ({pc, a_reg, d_reg, mem[8'h30]} !== {16'h0030, 16'h0001, 16'h0001, 16'h0001}) begin
            failures++;
            $display("FAIL jmp_pre_wb_a pc/a/d/m=%h/%h/%h/%h required=0030/0001/0001/0001",
                     pc, a_reg, d_reg, mem[8'h30]);
        end
    endtask

    task automatic test_pc_wrap();
        send(16'h0000, 1);
        send(16'hEEA0, 1);
        send(16'hEA87, 1);
        wait_ready();
        checks++;
        if (pc !== 16'hFFFF) begin
            failures++;
            $display("FAIL pc_setup pc=%h required=ffff", pc);
        end
        send(16'h0001, 1);
        wait_ready();
        checks++;
        if (pc !== 16'h0000) begin
            failures++;
            $display("FAIL pc_wrap pc=%h required=0000", pc);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] m1;
        send(16'h0007, 1);
        send(16'hEC10, 1);
        send(16'h0001, 1);
        wait_ready();
        m1 = model_mem[1];
        send(16'hE308, 0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_we, res_valid, instr_ready, zx, nx, zy, ny, f, no} !== 9'd0 || alu_x !== 16'd0) begin
            failures++;
            $display("FAIL abort_during got=%b x=%h required=000000000 x=0000",
                     {m_we, res_valid, instr_ready, zx, nx, zy, ny, f, no}, alu_x);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        ma = '0; md = '0; mpc = '0;
        @(negedge clk);
        checks++;
        if ({pc, a_reg, d_reg} !== 48'd0 || res_valid !== 1'b0 || m_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_after pc/a/d=%h/%h/%h vld=%b we=%b required=0/0/0 0 0",
                     pc, a_reg, d_reg, res_valid, m_we);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || m_we !== 1'b0 || mem[1] !== m1) begin
            failures++;
            $display("FAIL abort_no_effect vld=%b we=%b mem1=%h required=0 0 %h", res_valid, m_we, mem[1], m1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 0)
                ins = {1'b0, 7'd0, 8'($urandom)};
            else
                ins = {1'b1, 2'($urandom), 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
            send(ins, 1);
        end
        wait_ready();
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain pending=%0d required=0", expq.size());
        end
    endtask

`ifdef ALU_SEQ_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        test_reset();
        checks++;
        if (retired !== 16'd0) begin
            failures++;
            $display("FAIL retired_reset got=%0d required=0", retired);
        end
        send(16'h0001, 1);
        send(16'h0002, 1);
        send(16'hEC10, 1);
        wait_ready();
        @(negedge clk);
        checks++;
        if (retired !== 16'd3) begin
            failures++;
            $display("FAIL retired_count got=%0d required=3", retired);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (retired !== 16'd3) begin
            failures++;
            $display("FAIL retired_idle got=%0d required=3", retired);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            model_mem[i] = '0;
        end
        test_reset();
        test_a_instr();
        test_c_dest_d();
        test_mem_write();
        test_jump();
        test_pc_wrap();
        test_reset_abort();
        test_back_to_back();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
